// File: rtl/serial_bit_collector_if.sv
// Bus between the switch/key front end and the pattern recognizer:
// raw board inputs in, sliding window and status out.
interface serial_bit_collector_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   // Strobe semantics: there is no ready. shift_pulse is high for exactly one
   // cycle, and in that cycle data_out/bit_count/data_valid already show the
   // new bit. A consumer samples whenever shift_pulse is high.
   logic             key_n;
   logic             bit_in;
   logic             clear;
   logic [WIDTH-1:0] data_out;
   logic [CW-1:0]    bit_count;
   logic             data_valid;
   logic             shift_pulse;
   logic [1:0]       dbg_state;

   modport master (
      output key_n, bit_in, clear,
      input  data_out, bit_count, data_valid, shift_pulse, dbg_state
   );

   modport slave (
      input  key_n, bit_in, clear,
      output data_out, bit_count, data_valid, shift_pulse, dbg_state
   );
endinterface

// File: rtl/serial_bit_collector.sv
// Debounced push-button sampler: each accepted press shifts the synchronized
// switch bit into a WIDTH-bit sliding window.
module serial_bit_collector #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input logic                    clk,
   input logic                    reset_n,
   serial_bit_collector_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic             key_meta, key_sync;
   logic             bit_meta, bit_sync;
   state_t           state_q, state_d;
   logic [DW-1:0]    cnt_q, cnt_d;
   logic             shift_req;
   logic [WIDTH-1:0] data_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_inc;
   logic             valid_q;
   logic             pulse_q;

   // Key idles high, so its synchronizer resets high: no phantom press at reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_meta <= 1'b1;
         key_sync <= 1'b1;
         bit_meta <= 1'b0;
         bit_sync <= 1'b0;
      end else begin
         key_meta <= bus.key_n;
         key_sync <= key_meta;
         bit_meta <= bus.bit_in;
         bit_sync <= bit_meta;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_req = 1'b0;
      case (state_q)
         IDLE: begin
            if (!key_sync) begin
               state_d = PRESS_WAIT;
               cnt_d   = DW'(1);
            end
         end
         PRESS_WAIT: begin
            if (key_sync) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DW'(DEBOUNCE_CYCLES)) begin
               state_d   = PRESSED;
               shift_req = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (key_sync) begin
               state_d = RELEASE_WAIT;
               cnt_d   = DW'(1);
            end
         end
         RELEASE_WAIT: begin
            // A low blip during release returns to PRESSED without shifting.
            if (!key_sync) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == DW'(DEBOUNCE_CYCLES)) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign count_inc = (count_q == CW'(WIDTH)) ? count_q : count_q + 1'b1;

   // Clear has priority over a coincident shift and discards that bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         pulse_q <= 1'b0;
      end else if (bus.clear) begin
         data_q  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         pulse_q <= 1'b0;
      end else if (shift_req) begin
         data_q  <= {data_q[WIDTH-2:0], bit_sync};
         count_q <= count_inc;
         valid_q <= (count_inc == CW'(WIDTH));
         pulse_q <= 1'b1;
      end else begin
         pulse_q <= 1'b0;
      end
   end

   assign bus.data_out    = data_q;
   assign bus.bit_count   = count_q;
   assign bus.data_valid  = valid_q;
   assign bus.shift_pulse = pulse_q;
   assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_serial_bit_collector.sv
// Directed bench: presses push expected windows into a queue, a monitor pops
// and compares on every shift_pulse.
module tb_serial_bit_collector;
   localparam int WIDTH = 8;
   localparam int DEB   = 4;
   localparam int CW    = $clog2(WIDTH + 1);
   localparam int EW    = 1 + CW + WIDTH;

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_PRESS_WAIT = 2'd1;

   logic clk = 1'b0;
   logic reset_n;

   serial_bit_collector_if #(.WIDTH(WIDTH)) bus ();

   serial_bit_collector #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [EW-1:0]    exp_q[$];
   logic [WIDTH-1:0] exp_data;
   logic [CW-1:0]    exp_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_data = '0;
      exp_cnt  = '0;
   endtask

   task automatic model_shift(input logic b);
      exp_data = {exp_data[WIDTH-2:0], b};
      if (exp_cnt != CW'(WIDTH)) exp_cnt = exp_cnt + 1'b1;
      exp_q.push_back({(exp_cnt == CW'(WIDTH)), exp_cnt, exp_data});
   endtask

   // Clean press: low 10 cycles, high 10 cycles.
   task automatic press(input logic b, input logic expect_shift);
      @(negedge clk);
      bus.bit_in = b;
      bus.key_n  = 1'b0;
      if (expect_shift) model_shift(b);
      repeat (10) @(negedge clk);
      bus.key_n = 1'b1;
      repeat (10) @(negedge clk);
      check("press_shift_seen", exp_q.size(), 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_data"},  bus.data_out,    '0);
      check({tag, "_count"}, bus.bit_count,   '0);
      check({tag, "_valid"}, bus.data_valid,  '0);
      check({tag, "_pulse"}, bus.shift_pulse, '0);
   endtask

   // Monitor: every shift_pulse must match the oldest expected window.
   always @(negedge clk) begin
      if (reset_n && bus.shift_pulse) begin
         if (exp_q.size() == 0) begin
            check("unexpected_shift", 1, 0);
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("shift_data",  bus.data_out,   e[WIDTH-1:0]);
            check("shift_count", bus.bit_count,  e[WIDTH+CW-1:WIDTH]);
            check("shift_valid", bus.data_valid, e[EW-1]);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n     = 1'b0;
      bus.key_n   = 1'b0;
      bus.bit_in  = 1'b1;
      bus.clear   = 1'b0;
      model_reset();

      // Reset with key held low; key counts as a fresh press after release.
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      check("reset_state", bus.dbg_state, S_IDLE);
      reset_n = 1'b1;
      model_shift(1'b1);
      repeat (6) @(negedge clk);
      check("latency_early", bus.shift_pulse, 0);
      @(negedge clk);
      check("latency_edge", bus.shift_pulse, 1);
      bus.key_n = 1'b1;
      repeat (12) @(negedge clk);
      check("release_idle", bus.dbg_state, S_IDLE);

      // Bounce that never settles: no shift, back to IDLE.
      bus.key_n = 1'b0; repeat (2) @(negedge clk);
      bus.key_n = 1'b1; @(negedge clk);
      bus.key_n = 1'b0; repeat (2) @(negedge clk);
      bus.key_n = 1'b1; repeat (10) @(negedge clk);
      check("bounce_idle", bus.dbg_state, S_IDLE);
      check("bounce_count", bus.bit_count, 1);

      // Press with a one-cycle glitch during release: one shift only.
      bus.bit_in = 1'b0;
      bus.key_n  = 1'b0;
      model_shift(1'b0);
      repeat (10) @(negedge clk);
      bus.key_n = 1'b1; @(negedge clk);
      bus.key_n = 1'b0; @(negedge clk);
      bus.key_n = 1'b1; repeat (14) @(negedge clk);
      check("glitch_one_shift", exp_q.size(), 0);
      check("glitch_data", bus.data_out, 8'h02);

      // Clear, then eight presses MSB-first 0,0,0,0,0,1,0,0.
      bus.clear = 1'b1; @(negedge clk);
      bus.clear = 1'b0;
      model_reset();
      check("clear_data", bus.data_out, 0);
      check("clear_count", bus.bit_count, 0);
      for (int i = 0; i < 8; i++) press((i == 5), 1'b1);
      check("eight_data", bus.data_out, 8'h04);
      check("eight_valid", bus.data_valid, 1);

      // Saturated window keeps sliding.
      press(1'b1, 1'b1);
      check("sat_data", bus.data_out, 8'h09);
      check("sat_count", bus.bit_count, 8);

      // Clear exactly on the shift edge: bit discarded, no pulse.
      @(negedge clk);
      bus.bit_in = 1'b1;
      bus.key_n  = 1'b0;
      repeat (6) @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      model_reset();
      check_idle_outputs("clear_collide");
      bus.key_n = 1'b1;
      repeat (10) @(negedge clk);
      press(1'b1, 1'b1);
      check("after_clear_data", bus.data_out, 8'h01);
      check("after_clear_count", bus.bit_count, 1);

      // Clear held across a whole press: nothing accepted.
      bus.clear = 1'b1;
      press(1'b1, 1'b0);
      bus.clear = 1'b0;
      model_reset();
      @(negedge clk);
      check("clear_held_count", bus.bit_count, 0);
      press(1'b1, 1'b1);

      // Async reset in PRESS_WAIT with cnt=2, between clock edges.
      @(negedge clk);
      bus.bit_in = 1'b1;
      bus.key_n  = 1'b0;
      repeat (4) @(negedge clk);
      check("midpress_state", bus.dbg_state, S_PRESS_WAIT);
      #2;
      reset_n = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      check("async_reset_state", bus.dbg_state, S_IDLE);
      bus.key_n = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      check("post_reset_count", bus.bit_count, 0);
      press(1'b1, 1'b1);
      check("post_reset_data", bus.data_out, 8'h01);
      check("post_reset_count1", bus.bit_count, 1);

      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
